udp_frame_rx: RTL and testbench

// - Receive side of the 256-bit AXI-Stream Ethernet/IPv4/UDP test-frame path; consumes frames from the switch datapath.
// - Checks ethertype, IPv4 header and UDP destination port, then extracts source IP/port and the first 8 payload bytes.
// - Presents one result per accepted frame on a valid/ready port and keeps ok/drop frame counters.
// - Sits after the output-port lookup, in place of a host sink, to close the loop on the frame generator.

---
 rtl/udp_frame_rx_pkg.sv | 42 ++++
 rtl/udp_frame_rx_if.sv | 23 ++
 rtl/udp_frame_rx_hdr_check.sv | 57 +++++
 rtl/udp_frame_rx.sv | 132 +++++++++++++
 tb/tb_udp_frame_rx.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_frame_rx_pkg.sv
// Shared definitions for the UDP test-frame receiver: byte offsets, protocol constants,
// FSM state encoding and the result record.
package udp_frame_rx_pkg;

    localparam int BEAT_BYTES   = 32;

    localparam int DST_MAC_OFS  = 0;
    localparam int ETH_TYPE_OFS = 12;
    localparam int IP_VER_OFS   = 14;
    localparam int IP_PROTO_OFS = 23;
    localparam int IP_SRC_OFS   = 26;
    localparam int UDP_SRC_OFS  = 34;
    localparam int UDP_DST_OFS  = 36;
    localparam int UDP_LEN_OFS  = 38;
    localparam int PAYLOAD_OFS  = 42;
    localparam int PAYLOAD_LEN  = 8;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [15:0] UDP_MIN_LEN    = 16'd16;

    // Byte positions of the beat-1 fields, relative to the start of beat 1.
    localparam int B1_SRC_OFS = UDP_SRC_OFS - BEAT_BYTES;
    localparam int B1_DST_OFS = UDP_DST_OFS - BEAT_BYTES;
    localparam int B1_LEN_OFS = UDP_LEN_OFS - BEAT_BYTES;
    localparam int B1_PL_OFS  = PAYLOAD_OFS - BEAT_BYTES;
    localparam int B1_KEEP_N  = PAYLOAD_OFS + PAYLOAD_LEN - BEAT_BYTES;

    typedef enum logic [1:0] {
        S_BEAT0 = 2'd0,
        S_BEAT1 = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [15:0] src_port;
        logic [63:0] payload;
    } result_t;

endpackage

// File: rtl/udp_frame_rx_if.sv
// Frame input stream (AXI-Stream, 256-bit) and parsed-result port of the UDP receiver.
interface udp_axis_if;
    logic [255:0] tdata;
    logic [31:0]  tkeep;
    logic [127:0] tuser;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

interface udp_res_if;
    logic        valid;
    logic        ready;
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic [63:0] payload;

    modport master (output valid, src_ip, src_port, payload, input ready);
    modport slave  (input valid, src_ip, src_port, payload, output ready);
endinterface

// File: rtl/udp_frame_rx_hdr_check.sv
// Combinational header checks on one 256-bit beat; caller picks the beat-0 or beat-1 verdict.
// DST_MAC_FILTER_EN adds the destination-MAC check to the beat-0 verdict.
module udp_hdr_check
    import udp_frame_rx_pkg::*;
#(
    parameter logic [15:0] C_UDP_PORT  = 16'd2000,
    parameter logic [47:0] C_LOCAL_MAC = 48'h00e0ed2c2db6
) (
    input  logic [255:0] data_i,
    input  logic [31:0]  keep_i,
    output logic         beat0_ok_o,
    output logic         beat1_ok_o,
    output logic [31:0]  src_ip_o,
    output logic [15:0]  src_port_o,
    output logic [63:0]  payload_o
);

    // b[k] is byte k of the beat.
    logic [31:0][7:0] b;
    assign b = data_i;

    logic eth_ok, ver_ok, proto_ok, mac_ok;
    logic port_ok, len_ok, keep_ok;
    logic [15:0] udp_len;

    assign eth_ok   = {b[ETH_TYPE_OFS], b[ETH_TYPE_OFS+1]} == ETHERTYPE_IPV4;
    assign ver_ok   = b[IP_VER_OFS] == IP_VER_IHL;
    assign proto_ok = b[IP_PROTO_OFS] == IP_PROTO_UDP;

`ifdef DST_MAC_FILTER_EN
    logic [47:0] dst_mac;
    assign dst_mac = {b[DST_MAC_OFS],   b[DST_MAC_OFS+1], b[DST_MAC_OFS+2],
                      b[DST_MAC_OFS+3], b[DST_MAC_OFS+4], b[DST_MAC_OFS+5]};
    assign mac_ok  = (dst_mac == C_LOCAL_MAC) || (dst_mac == 48'hffffffffffff);
`else
    logic unused_mac;
    assign unused_mac = ^C_LOCAL_MAC;
    assign mac_ok     = 1'b1;
`endif

    assign beat0_ok_o = eth_ok & ver_ok & proto_ok & mac_ok;
    assign src_ip_o   = {b[IP_SRC_OFS], b[IP_SRC_OFS+1], b[IP_SRC_OFS+2], b[IP_SRC_OFS+3]};

    assign udp_len    = {b[B1_LEN_OFS], b[B1_LEN_OFS+1]};
    assign port_ok    = {b[B1_DST_OFS], b[B1_DST_OFS+1]} == C_UDP_PORT;
    assign len_ok     = udp_len >= UDP_MIN_LEN;
    // Every byte up to the end of the extracted payload must be present.
    assign keep_ok    = &keep_i[B1_KEEP_N-1:0];

    assign beat1_ok_o = port_ok & len_ok & keep_ok;
    assign src_port_o = {b[B1_SRC_OFS], b[B1_SRC_OFS+1]};
    assign payload_o  = data_i[8*B1_PL_OFS +: 64];

    logic unused_in;
    assign unused_in = ^{data_i, keep_i[31:B1_KEEP_N]};

endmodule

// File: rtl/udp_frame_rx.sv
// UDP test-frame receiver: checks Eth/IPv4/UDP headers, emits src IP/port + 8 payload bytes, counts ok/drop.
// Result and counters update the cycle after the deciding beat; DST_MAC_FILTER_EN enables the dst-MAC check.
// Input stalls (tready low) while a result is pending and m_ready is low.
module udp_frame_rx
    import udp_frame_rx_pkg::*;
#(
    parameter int          C_S_AXIS_DATA_WIDTH  = 256,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter logic [15:0] C_UDP_PORT           = 16'd2000,
    parameter logic [47:0] C_LOCAL_MAC          = 48'h00e0ed2c2db6,
    parameter int          C_CNT_WIDTH          = 32
) (
    input  logic                   axis_aclk,
    input  logic                   axis_reset,
    udp_axis_if.slave              s_axis,
    udp_res_if.master              m_res,
    output logic [C_CNT_WIDTH-1:0] frames_ok,
    output logic [C_CNT_WIDTH-1:0] frames_drop
);

    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic                   hdr_ok_q, hdr_ok_d;
    logic [31:0]            ip_q, ip_d;
    logic                   vld_q, vld_d;
    result_t                res_q, res_d;
    logic [C_CNT_WIDTH-1:0] ok_q, ok_d;
    logic [C_CNT_WIDTH-1:0] drop_q, drop_d;

    logic        tready;
    logic        xfer;
    logic        beat0_ok, beat1_ok;
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic [63:0] payload;

    udp_hdr_check #(
        .C_UDP_PORT  (C_UDP_PORT),
        .C_LOCAL_MAC (C_LOCAL_MAC)
    ) u_hdr_check (
        .data_i     (s_axis.tdata),
        .keep_i     (s_axis.tkeep),
        .beat0_ok_o (beat0_ok),
        .beat1_ok_o (beat1_ok),
        .src_ip_o   (src_ip),
        .src_port_o (src_port),
        .payload_o  (payload)
    );

    assign tready        = ~(vld_q & ~m_res.ready);
    assign xfer          = s_axis.tvalid & tready;
    assign s_axis.tready = tready;

    always_comb begin
        state_d  = state_q;
        hdr_ok_d = hdr_ok_q;
        ip_d     = ip_q;
        vld_d    = vld_q;
        res_d    = res_q;
        ok_d     = ok_q;
        drop_d   = drop_q;

        if (vld_q && m_res.ready) begin
            vld_d = 1'b0;
        end

        case (state_q)
            S_BEAT0: begin
                if (xfer) begin
                    hdr_ok_d = beat0_ok;
                    ip_d     = src_ip;
                    if (s_axis.tlast) begin
                        drop_d = drop_q + CNT_ONE;
                    end else begin
                        state_d = S_BEAT1;
                    end
                end
            end
            S_BEAT1: begin
                if (xfer) begin
                    // A load here may coincide with m_ready retiring the old result.
                    if (hdr_ok_q && beat1_ok) begin
                        vld_d = 1'b1;
                        res_d = '{src_ip: ip_q, src_port: src_port, payload: payload};
                        ok_d  = ok_q + CNT_ONE;
                    end else begin
                        drop_d = drop_q + CNT_ONE;
                    end
                    state_d = s_axis.tlast ? S_BEAT0 : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (xfer && s_axis.tlast) begin
                    state_d = S_BEAT0;
                end
            end
            default: state_d = S_BEAT0;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_q  <= S_BEAT0;
            hdr_ok_q <= 1'b0;
            ip_q     <= '0;
            vld_q    <= 1'b0;
            res_q    <= '0;
            ok_q     <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            hdr_ok_q <= hdr_ok_d;
            ip_q     <= ip_d;
            vld_q    <= vld_d;
            res_q    <= res_d;
            ok_q     <= ok_d;
            drop_q   <= drop_d;
        end
    end

    assign m_res.valid    = vld_q;
    assign m_res.src_ip   = res_q.src_ip;
    assign m_res.src_port = res_q.src_port;
    assign m_res.payload  = res_q.payload;
    assign frames_ok      = ok_q;
    assign frames_drop    = drop_q;

    logic unused_cfg;
    assign unused_cfg = ^{s_axis.tuser, C_S_AXIS_DATA_WIDTH, C_S_AXIS_TUSER_WIDTH};

endmodule

// File: tb/tb_udp_frame_rx.sv
// Scoreboard bench for udp_frame_rx: directed frames push expected results, a monitor pops on handshake.
module tb_udp_frame_rx;
    import udp_frame_rx_pkg::*;

    localparam logic [47:0] LOCAL_MAC = 48'h00e0ed2c2db6;
    localparam logic [63:0] REF_PL    = 64'h4941564154534F43;

    logic        axis_aclk = 1'b0;
    logic        axis_reset;
    logic [31:0] frames_ok;
    logic [31:0] frames_drop;

    always #5 axis_aclk = ~axis_aclk;

    udp_axis_if s_axis ();
    udp_res_if  m_res ();

    udp_frame_rx #(
        .C_S_AXIS_DATA_WIDTH  (256),
        .C_S_AXIS_TUSER_WIDTH (128),
        .C_UDP_PORT           (16'd2000),
        .C_LOCAL_MAC          (LOCAL_MAC),
        .C_CNT_WIDTH          (32)
    ) dut (
        .axis_aclk   (axis_aclk),
        .axis_reset  (axis_reset),
        .s_axis      (s_axis),
        .m_res       (m_res),
        .frames_ok   (frames_ok),
        .frames_drop (frames_drop)
    );

    int      total_cnt = 0;
    int      pass_cnt  = 0;
    int      exp_ok    = 0;
    int      exp_drop  = 0;
    result_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Monitor: compare every accepted result against the head of the scoreboard.
    always @(negedge axis_aclk) begin
        result_t e;
        if (!axis_reset && m_res.valid && m_res.ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_result: got src_ip %h port %h, required no result",
                         m_res.src_ip, m_res.src_port);
            end else begin
                e = exp_q.pop_front();
                chk("m_src_ip",   64'(m_res.src_ip),   64'(e.src_ip));
                chk("m_src_port", 64'(m_res.src_port), 64'(e.src_port));
                chk("m_payload",  m_res.payload,       e.payload);
            end
        end
    end

    task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
        int n;
        n = 0;
        s_axis.tdata  = d;
        s_axis.tkeep  = k;
        s_axis.tlast  = l;
        s_axis.tvalid = 1'b1;
        @(negedge axis_aclk);
        while (!s_axis.tready && n < 200) begin
            @(negedge axis_aclk);
            n++;
        end
        if (!s_axis.tready) begin
            total_cnt++;
            $display("FAIL beat_timeout: tready 0 after %0d cycles, required 1", n);
        end
        @(posedge axis_aclk);
        #1;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic build_frame(input logic [47:0] dmac, input logic [31:0] ip,
                               input logic [15:0] sport, input logic [15:0] dport,
                               input logic [15:0] ulen, input int ovr_idx,
                               input logic [7:0] ovr_val,
                               output logic [255:0] b0, output logic [255:0] b1);
        logic [7:0] fb [64];
        string      pl;
        pl = "COSTAVAI";
        for (int i = 0; i < 64; i++) fb[i] = 8'(i * 3 + 1);
        for (int i = 0; i < 6; i++)  fb[i] = dmac[8*(5-i) +: 8];
        fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45; fb[23] = 8'h11;
        for (int i = 0; i < 4; i++)  fb[26+i] = ip[8*(3-i) +: 8];
        fb[34] = sport[15:8]; fb[35] = sport[7:0];
        fb[36] = dport[15:8]; fb[37] = dport[7:0];
        fb[38] = ulen[15:8];  fb[39] = ulen[7:0];
        for (int i = 0; i < 8; i++)  fb[42+i] = pl[i];
        if (ovr_idx >= 0) fb[ovr_idx] = ovr_val;
        for (int i = 0; i < 32; i++) begin
            b0[8*i +: 8] = fb[i];
            b1[8*i +: 8] = fb[32+i];
        end
    endtask

    // Send one frame; an accepted frame pushes its expected result first.
    task automatic run(input logic [47:0] dmac, input logic [31:0] ip, input logic [15:0] sport,
                       input logic [15:0] dport, input logic [15:0] ulen, input int ovr_idx,
                       input logic [7:0] ovr_val, input int nbeats, input logic [31:0] keep1,
                       input bit accept);
        logic [255:0] b0, b1;
        build_frame(dmac, ip, sport, dport, ulen, ovr_idx, ovr_val, b0, b1);
        if (accept) begin
            exp_q.push_back('{src_ip: ip, src_port: sport, payload: REF_PL});
            exp_ok++;
        end else begin
            exp_drop++;
        end
        if (nbeats == 1) begin
            send_beat(b0, 32'hffffffff, 1'b1);
        end else begin
            send_beat(b0, 32'hffffffff, 1'b0);
            send_beat(b1, keep1, nbeats == 2);
            if (nbeats == 3) send_beat({8{32'hdeadbeef}}, 32'h0000000f, 1'b1);
        end
    endtask

    task automatic settle(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge axis_aclk);
            n++;
        end
        repeat (2) @(negedge axis_aclk);
        chk({name, "_pending"},     64'(exp_q.size()), 64'd0);
        chk({name, "_frames_ok"},   64'(frames_ok),    64'(exp_ok));
        chk({name, "_frames_drop"}, 64'(frames_drop),  64'(exp_drop));
        chk({name, "_m_valid"},     64'(m_res.valid),  64'd0);
        @(posedge axis_aclk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] b0, b1;
        int           base;
        s_axis.tdata  = '0;
        s_axis.tkeep  = '0;
        s_axis.tuser  = '0;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        m_res.ready   = 1'b1;
        axis_reset    = 1'b1;
        repeat (3) @(posedge axis_aclk);
        #1;
        chk("rst_m_valid",     64'(m_res.valid),    64'd0);
        chk("rst_frames_ok",   64'(frames_ok),      64'd0);
        chk("rst_frames_drop", 64'(frames_drop),    64'd0);
        chk("rst_m_src_ip",    64'(m_res.src_ip),   64'd0);
        chk("rst_m_payload",   m_res.payload,       64'd0);
        chk("rst_tready",      64'(s_axis.tready),  64'd1);
        axis_reset = 1'b0;
        @(posedge axis_aclk);
        #1;

        // Reference frame 192.168.0.1:2000 -> 2000, "COSTAVAI"
        run(LOCAL_MAC, 32'hC0A80001, 16'h07D0, 16'd2000, 16'd22, -1, 8'h00, 2, 32'h0003ffff, 1);
        settle("ref");

        run(LOCAL_MAC, 32'hC0A80001, 16'h07D0, 16'd2000, 16'd22, 23, 8'h06, 2, 32'h0003ffff, 0);
        settle("proto_tcp");

        run(LOCAL_MAC, 32'hC0A80001, 16'h07D0, 16'd2000, 16'd22, -1, 8'h00, 1, 32'h0003ffff, 0);
        run(LOCAL_MAC, 32'h0A000005, 16'h04D2, 16'd2000, 16'd22, -1, 8'h00, 2, 32'h0003ffff, 1);
        settle("runt_then_ref");

        run(LOCAL_MAC, 32'hAC100203, 16'h1234, 16'd2000, 16'd22, -1, 8'h00, 3, 32'hffffffff, 1);
        run(LOCAL_MAC, 32'hC0A80001, 16'h07D0, 16'd2000, 16'd22, -1, 8'h00, 2, 32'h0003ffff, 1);
        settle("drain");

        run(LOCAL_MAC, 32'h01020304, 16'h0505, 16'd2000, 16'd16, -1, 8'h00, 2, 32'h0003ffff, 1);
        run(LOCAL_MAC, 32'h01020304, 16'h0505, 16'd2000, 16'd15, -1, 8'h00, 2, 32'h0003ffff, 0);
        run(LOCAL_MAC, 32'h01020304, 16'h0505, 16'd2001, 16'd22, -1, 8'h00, 2, 32'h0003ffff, 0);
        run(LOCAL_MAC, 32'h01020304, 16'h0505, 16'd2000, 16'd22, -1, 8'h00, 2, 32'h0001ffff, 0);
        run(LOCAL_MAC, 32'h01020304, 16'h0505, 16'd2000, 16'd22, 14, 8'h46, 2, 32'h0003ffff, 0);
        run(LOCAL_MAC, 32'h01020304, 16'h0505, 16'd2000, 16'd22, 13, 8'h01, 2, 32'h0003ffff, 0);
        settle("boundaries");

`ifdef DST_MAC_FILTER_EN
        run(48'h112233445566, 32'hC0A80001, 16'h07D0, 16'd2000, 16'd22, -1, 8'h00, 2, 32'h0003ffff, 0);
        run(48'hffffffffffff, 32'hC0A80009, 16'h07D0, 16'd2000, 16'd22, -1, 8'h00, 2, 32'h0003ffff, 1);
        settle("mac_filter");
`else
        run(48'h112233445566, 32'hC0A80001, 16'h07D0, 16'd2000, 16'd22, -1, 8'h00, 2, 32'h0003ffff, 1);
        settle("mac_ignored");
`endif

        // Two frames with m_ready held low: the second must stall behind the first result.
        base = exp_ok;
        m_res.ready = 1'b0;
        fork
            begin
                run(LOCAL_MAC, 32'hC0A80011, 16'h0101, 16'd2000, 16'd22, -1, 8'h00, 2, 32'h0003ffff, 1);
                run(LOCAL_MAC, 32'hC0A80022, 16'h0202, 16'd2000, 16'd22, -1, 8'h00, 2, 32'h0003ffff, 1);
            end
            begin
                int n;
                n = 0;
                while (frames_ok != 32'(base + 1) && n < 100) begin
                    @(negedge axis_aclk);
                    n++;
                end
                repeat (3) @(negedge axis_aclk);
                chk("stall_tready",    64'(s_axis.tready), 64'd0);
                chk("stall_m_valid",   64'(m_res.valid),   64'd1);
                chk("stall_frames_ok", 64'(frames_ok),     64'(base + 1));
                @(posedge axis_aclk);
                #1;
                m_res.ready = 1'b1;
            end
        join
        settle("backpressure");

        // Reset after beat 0: the following beat is parsed as a fresh (runt) frame.
        build_frame(LOCAL_MAC, 32'hC0A80001, 16'h07D0, 16'd2000, 16'd22, -1, 8'h00, b0, b1);
        send_beat(b0, 32'hffffffff, 1'b0);
        axis_reset = 1'b1;
        @(posedge axis_aclk);
        #1;
        axis_reset = 1'b0;
        exp_ok   = 0;
        exp_drop = 0;
        chk("midrst_frames_ok",   64'(frames_ok),   64'd0);
        chk("midrst_frames_drop", 64'(frames_drop), 64'd0);
        send_beat(b1, 32'h0003ffff, 1'b1);
        exp_drop++;
        run(LOCAL_MAC, 32'hC0A80001, 16'h07D0, 16'd2000, 16'd22, -1, 8'h00, 2, 32'h0003ffff, 1);
        settle("mid_reset");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
